race_logic_multi: RTL and testbench

Parametrised multi-player successor to the single-player click-race logic. It runs one race for `N_PLAYERS` lanes that share one red/green light. Each lane counts debounced click edges into steps and is eliminated if it clicks on red. Finishing places are allocated centrally, and ties share a place. It sits between the click synchronisers/debouncers and the display/score blocks.

---
 rtl/race_pkg.sv | 22 ++
 rtl/race_lane.sv | 64 ++++++
 rtl/race_logic_multi.sv | 96 +++++++++
 tb/tb_race_logic_multi.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/race_pkg.sv
// Shared types for the multi-lane click race: lane/game state encodings and
// the width helper for place fields.
package race_pkg;

   typedef enum logic [1:0] {
      L_IDLE   = 2'b00,
      L_ACTIVE = 2'b01,
      L_FIN    = 2'b10,
      L_OUT    = 2'b11
   } lane_state_t;

   typedef enum logic [1:0] {
      G_IDLE = 2'b00,
      G_RUN  = 2'b01,
      G_DONE = 2'b10
   } game_state_t;

   function automatic int place_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/race_lane.sv
// One race lane: click edge detector, click/step counters and lane state.
// Edges are registered once before they act, so updates land one edge after detection.
module race_lane
   import race_pkg::*;
#(
   parameter int CLICK_W = 5,
   parameter int STEP_W  = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_run,
   input  logic               run,
   input  logic               enable,
   input  logic               red,
   input  logic               click,
   input  logic [CLICK_W-1:0] max_clicks,
   input  logic [STEP_W-1:0]  max_steps,
   output logic [STEP_W-1:0]  position,
   output lane_state_t        state,
   output logic               finish_now
);

   logic               click_q, ev_q, red_q;
   logic [CLICK_W-1:0] clicks;
   logic               hit, wrap;

   always_comb begin
      hit        = run && (state == L_ACTIVE) && ev_q && !red_q;
      wrap       = ({1'b0, clicks} + (CLICK_W+1)'(1)) >= {1'b0, max_clicks};
      finish_now = hit && wrap && ((position + STEP_W'(1)) == max_steps);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         click_q  <= 1'b0;
         ev_q     <= 1'b0;
         red_q    <= 1'b0;
         clicks   <= '0;
         position <= '0;
         state    <= L_IDLE;
      end else begin
         click_q <= click;
         // an edge seen on the start edge belongs to no race and is dropped
         ev_q    <= click & ~click_q & enable & ~start_run;
         red_q   <= red;
         if (start_run) begin
            clicks   <= '0;
            position <= '0;
            state    <= L_ACTIVE;
         end else if (run && (state == L_ACTIVE) && ev_q) begin
            if (red_q) begin
               state <= L_OUT;
            end else if (!wrap) begin
               clicks <= clicks + CLICK_W'(1);
            end else begin
               clicks   <= '0;
               position <= position + STEP_W'(1);
               if (finish_now) state <= L_FIN;
            end
         end
      end
   end

endmodule

// File: rtl/race_logic_multi.sv
// Multi-lane click race: game FSM, latched limits and central place allocation;
// lanes finishing on the same edge share a place.
module race_logic_multi
   import race_pkg::*;
#(
   parameter int N_PLAYERS = 4,
   parameter int CLICK_W   = 5,
   parameter int STEP_W    = 3,
   parameter int PLACE_W   = place_w(N_PLAYERS)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic                                enable,
   input  logic                                red,
   input  logic [N_PLAYERS-1:0]                click,
   input  logic [CLICK_W-1:0]                  max_clicks,
   input  logic [STEP_W-1:0]                   max_steps,
   output logic [N_PLAYERS-1:0][STEP_W-1:0]    position,
   output logic [N_PLAYERS-1:0][1:0]           lane_state,
   output logic [N_PLAYERS-1:0][PLACE_W-1:0]   place,
   output logic                                racing,
   output logic                                game_over
);

   game_state_t          gs;
   logic [CLICK_W-1:0]   mc;
   logic [STEP_W-1:0]    ms;
   logic [PLACE_W:0]     next_place, n_fin;
   logic                 start_run, run;
   logic [N_PLAYERS-1:0] fin, active;
   lane_state_t          ls [N_PLAYERS];

   assign start_run = start && (gs != G_RUN);
   assign run       = (gs == G_RUN);

   for (genvar g = 0; g < N_PLAYERS; g++) begin : g_lane
      race_lane #(.CLICK_W(CLICK_W), .STEP_W(STEP_W)) u_lane (
         .clk        (clk),
         .rst        (rst),
         .start_run  (start_run),
         .run        (run),
         .enable     (enable),
         .red        (red),
         .click      (click[g]),
         .max_clicks (mc),
         .max_steps  (ms),
         .position   (position[g]),
         .state      (ls[g]),
         .finish_now (fin[g])
      );
      assign lane_state[g] = ls[g];
      assign active[g]     = (ls[g] == L_ACTIVE);
   end

   always_comb begin
      n_fin = '0;
      for (int i = 0; i < N_PLAYERS; i++) n_fin = n_fin + (PLACE_W+1)'(fin[i]);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         gs         <= G_IDLE;
         racing     <= 1'b0;
         game_over  <= 1'b0;
         mc         <= '0;
         ms         <= '0;
         next_place <= '0;
         place      <= '0;
      end else begin
         case (gs)
            G_IDLE, G_DONE: if (start) begin
               gs         <= G_RUN;
               racing     <= 1'b1;
               game_over  <= 1'b0;
               mc         <= (max_clicks == '0) ? CLICK_W'(1) : max_clicks;
               ms         <= (max_steps == '0) ? STEP_W'(1) : max_steps;
               next_place <= (PLACE_W+1)'(1);
               place      <= '0;
            end
            G_RUN: begin
               for (int i = 0; i < N_PLAYERS; i++)
                  if (fin[i]) place[i] <= next_place[PLACE_W-1:0];
               next_place <= next_place + n_fin;
               if (active == '0) begin
                  gs        <= G_DONE;
                  racing    <= 1'b0;
                  game_over <= 1'b1;
               end
            end
            default: gs <= G_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_race_logic_multi.sv
// Directed race scenarios; expected snapshots are queued with the cycle they
// are due and a negedge monitor compares them against the outputs.
module tb_race_logic_multi;

   localparam int N = 4, CW = 5, SW = 3, PW = 3;

   logic clk = 1'b0, rst = 1'b0, start = 1'b0, enable = 1'b1, red = 1'b0;
   logic [N-1:0]    click = '0;
   logic [CW-1:0]   max_clicks = '0;
   logic [SW-1:0]   max_steps = '0;
   logic [N*SW-1:0] position;
   logic [N*2-1:0]  lane_state;
   logic [N*PW-1:0] place;
   logic            racing, game_over;

   race_logic_multi #(.N_PLAYERS(N), .CLICK_W(CW), .STEP_W(SW)) dut (
      .clk(clk), .rst(rst), .start(start), .enable(enable), .red(red),
      .click(click), .max_clicks(max_clicks), .max_steps(max_steps),
      .position(position), .lane_state(lane_state), .place(place),
      .racing(racing), .game_over(game_over)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int              due;
      string           name;
      logic [N*SW-1:0] pos;
      logic [N*2-1:0]  st;
      logic [N*PW-1:0] pl;
      logic            rc;
      logic            go;
   } exp_t;

   exp_t q[$];
   int   compared = 0, mismatched = 0;
   int   ep[N], est[N], epl[N];
   int   erc, ego;

   always @(negedge clk) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
         exp_t e;
         e = q.pop_front();
         compared++;
         if (e.due != cyc || position !== e.pos || lane_state !== e.st || place !== e.pl ||
             racing !== e.rc || game_over !== e.go) begin
            mismatched++;
            $display("FAIL %s cyc=%0d got pos=%h st=%h pl=%h rc=%b go=%b want pos=%h st=%h pl=%h rc=%b go=%b",
                     e.name, cyc, position, lane_state, place, racing, game_over,
                     e.pos, e.st, e.pl, e.rc, e.go);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string nm);
      exp_t e;
      e.due = cyc; e.name = nm;
      for (int i = 0; i < N; i++) begin
         e.pos[i*SW +: SW] = SW'(ep[i]);
         e.st[i*2 +: 2]    = 2'(est[i]);
         e.pl[i*PW +: PW]  = PW'(epl[i]);
      end
      e.rc = 1'(erc); e.go = 1'(ego);
      q.push_back(e);
   endtask

   task automatic set_all(input int st, input int rc);
      for (int i = 0; i < N; i++) begin ep[i] = 0; est[i] = st; epl[i] = 0; end
      erc = rc; ego = 0;
   endtask

   // one click edge on the lanes in m; returns right after the edge that applies it
   task automatic pulse(input logic [N-1:0] m, input logic r, input logic en);
      click = m; red = r; enable = en;
      tick();
      click = '0; red = 1'b0; enable = 1'b1;
      tick();
   endtask

   task automatic do_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   initial begin
      // reset
      tick(); tick();
      set_all(0, 0); push("reset");
      rst = 1'b1; tick();

      // race 1: 2 clicks/step, 2 steps
      max_clicks = 5'd2; max_steps = 3'd2;
      do_start();
      set_all(1, 1); push("start1");
      max_clicks = 5'd5;
      pulse(4'b0001, 0, 1); push("l0_e1");
      pulse(4'b0001, 0, 1); ep[0] = 1; push("l0_e2");
      pulse(4'b0001, 0, 1); push("l0_e3");
      pulse(4'b0001, 0, 1); ep[0] = 2; est[0] = 2; epl[0] = 1; push("l0_finish");
      pulse(4'b0010, 0, 1); push("l1_green");
      pulse(4'b0010, 1, 1); est[1] = 3; push("l1_red_out");
      pulse(4'b0010, 0, 1); push("l1_after_out");
      pulse(4'b0100, 0, 0); push("enable_low");
      pulse(4'b1100, 0, 1); pulse(4'b1100, 0, 1); ep[2] = 1; ep[3] = 1; push("tie_step1");
      pulse(4'b1100, 0, 1); pulse(4'b1100, 0, 1);
      ep[2] = 2; ep[3] = 2; est[2] = 2; est[3] = 2; epl[2] = 2; epl[3] = 2; push("tie_place2");
      tick(); erc = 0; ego = 1; push("game_over1");

      // race 2: max_clicks 0 acts as 1, click held across start
      click = 4'b0001; tick();
      max_clicks = 5'd0; max_steps = 3'd1;
      do_start();
      set_all(1, 1); push("start2");
      click = '0; tick(); tick(); push("held_no_count");
      pulse(4'b0011, 0, 1);
      ep[0] = 1; ep[1] = 1; est[0] = 2; est[1] = 2; epl[0] = 1; epl[1] = 1; push("tie_place1");
      pulse(4'b0100, 0, 1); ep[2] = 1; est[2] = 2; epl[2] = 3; push("after_tie_place3");
      pulse(4'b1000, 1, 1); est[3] = 3; push("last_red");
      tick(); erc = 0; ego = 1; push("game_over2");

      // race 3: reset mid-race, then a fresh race restarts placing at 1
      max_clicks = 5'd2; max_steps = 3'd2;
      do_start();
      set_all(1, 1); push("start3");
      pulse(4'b0001, 0, 1); pulse(4'b0001, 0, 1); ep[0] = 1; push("pre_reset");
      rst = 1'b0; start = 1'b1; tick(); rst = 1'b1; start = 1'b0;
      set_all(0, 0); push("mid_reset");
      do_start();
      set_all(1, 1); push("start4");
      for (int k = 0; k < 4; k++) pulse(4'b0001, 0, 1);
      ep[0] = 2; est[0] = 2; epl[0] = 1; push("place1_after_reset");

      tick(); tick();
      if (q.size() != 0) begin
         mismatched++;
         $display("FAIL drain pending=%0d want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
